// File: rtl/regfile_param.sv
// Multi-read-port register file with a hardware clear sweep that zeroes one entry per cycle.
// Define REGFILE_BYPASS_EN to forward same-edge write data to matching read ports.
module regfile_param #(
  parameter int unsigned DATA_W = 72,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NRD    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic [ADDR_W-1:0]     clr_ptr_q;
  logic [NRD*DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0]     mem_q [Depth];

  logic                  wr_fire;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     rd_word [NRD];

  assign wr_fire   = wr_en & ~busy_q;
  // The sweep and user writes are mutually exclusive, so one write port suffices.
  assign mem_we    = busy_q | wr_fire;
  assign mem_waddr = busy_q ? clr_ptr_q : wr_addr;
  assign mem_wdata = busy_q ? '0 : wr_data;

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_word[k] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (rd_addr[k*ADDR_W +: ADDR_W] == wr_addr)) begin
        rd_word[k] = wr_data;
      end
`endif
    end
  end

  // Storage is deliberately outside the async reset; only the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StClear;
      busy_q    <= 1'b1;
      clr_ptr_q <= '0;
      rd_data_q <= '0;
    end else begin
      for (int k = 0; k < NRD; k++) begin
        rd_data_q[k*DATA_W +: DATA_W] <= busy_q ? '0 : rd_word[k];
      end
      unique case (state_q)
        StIdle: begin
          if (clear_req) begin
            state_q   <= StClear;
            busy_q    <= 1'b1;
            clr_ptr_q <= '0;
          end
        end
        StClear: begin
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StClear;
          busy_q    <= 1'b1;
          clr_ptr_q <= '0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign wr_ready = ~busy_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: the driver pushes model predictions, a monitor pops them.
// The reference model honours REGFILE_BYPASS_EN the same way the build does.
module tb_regfile_param;

  localparam int unsigned DATA_W = 72;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned NRD    = 2;
  localparam int unsigned Depth  = 1 << ADDR_W;
`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic                  clear_req;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_ready;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;

  regfile_param #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NRD   (NRD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  typedef struct packed {
    logic [NRD*DATA_W-1:0] rd;
    logic                  busy;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;

  // Model: a clear zeroes everything at once and blocks access for Depth cycles.
  logic [DATA_W-1:0] mdl_mem [Depth];
  int                busy_left = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (rd_data !== mon_e.rd) begin
        n_err++;
        $display("FAIL rd_data t=%0t got %h exp %h", $time, rd_data, mon_e.rd);
      end
      n_vec++;
      if (busy !== mon_e.busy) begin
        n_err++;
        $display("FAIL busy t=%0t got %b exp %b", $time, busy, mon_e.busy);
      end
      n_vec++;
      if (wr_ready !== ~mon_e.busy) begin
        n_err++;
        $display("FAIL wr_ready t=%0t got %b exp %b", $time, wr_ready, ~mon_e.busy);
      end
    end
  end

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return ADDR_W'(7);
      3:       return ADDR_W'(3);
      default: return ADDR_W'($urandom());
    endcase
  endfunction

  function automatic logic [NRD*ADDR_W-1:0] rand_ra();
    logic [NRD*ADDR_W-1:0] r;
    for (int k = 0; k < NRD; k++) r[k*ADDR_W +: ADDR_W] = rand_addr();
    return r;
  endfunction

  function automatic logic [NRD*ADDR_W-1:0] pair(input logic [ADDR_W-1:0] a0,
                                                 input logic [ADDR_W-1:0] a1);
    logic [NRD*ADDR_W-1:0] r;
    for (int k = 0; k < NRD; k++) r[k*ADDR_W +: ADDR_W] = (k % 2 == 0) ? a0 : a1;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  // Called at a falling edge; drives one cycle of inputs and predicts the response.
  task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic clr, input logic [NRD*ADDR_W-1:0] ra);
    exp_t              e;
    logic [ADDR_W-1:0] a;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    clear_req = clr;
    rd_addr   = ra;
    for (int k = 0; k < NRD; k++) begin
      a = ra[k*ADDR_W +: ADDR_W];
      if (busy_left > 0) e.rd[k*DATA_W +: DATA_W] = '0;
      else if (Bypass && we && a == wa) e.rd[k*DATA_W +: DATA_W] = wd;
      else e.rd[k*DATA_W +: DATA_W] = mdl_mem[a];
    end
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (we) mdl_mem[wa] = wd;
      if (clr) begin
        for (int i = 0; i < int'(Depth); i++) mdl_mem[i] = '0;
        busy_left = Depth;
      end
    end
    e.busy = (busy_left > 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, rand_ra());
  endtask

  task automatic check_reset_state();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_busy got %b exp 1", busy);
    end
    n_vec++;
    if (wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wr_ready got %b exp 0", wr_ready);
    end
    n_vec++;
    if (rd_data !== '0) begin
      n_err++;
      $display("FAIL reset_rd_data got %h exp 0", rd_data);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where reset is released.
  task automatic do_reset(input int cycles);
    wr_en     = 1'b0;
    clear_req = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      check_reset_state();
      @(negedge clk);
    end
    reset = 1'b1;
    for (int i = 0; i < int'(Depth); i++) mdl_mem[i] = '0;
    busy_left = Depth;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    clear_req = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;
    @(negedge clk);
    do_reset(2);

    // Power-up sweep: writes attempted while busy must be dropped.
    for (int i = 0; i < int'(Depth) + 2; i++)
      step((i < int'(Depth)) ? 1'($urandom_range(0, 1)) : 1'b0, rand_addr(), rand_data(),
           1'b0, rand_ra());
    step(1'b0, '0, '0, 1'b0, pair('0, ADDR_W'(511)));
    step(1'b0, '0, '0, 1'b0, pair('1, '0));

    step(1'b1, '0, 72'hA5_DEADBEEF_CAFEF00D, 1'b0, pair('0, '0));
    step(1'b1, '1, 72'h01_23456789_ABCDEF01, 1'b0, pair('1, '1));
    step(1'b0, '0, '0, 1'b0, pair('0, '1));
    step(1'b0, '0, '0, 1'b0, pair('1, '0));
    step(1'b0, '0, '0, 1'b0, pair('0, '0));

    step(1'b1, ADDR_W'(7), 72'h55, 1'b0, pair(ADDR_W'(7), ADDR_W'(7)));
    step(1'b0, '0, '0, 1'b0, pair(ADDR_W'(7), '0));
    idle(1);

    // Write and clear in the same cycle, then hammer writes during the sweep.
    step(1'b1, ADDR_W'(3), 72'h77, 1'b1, pair(ADDR_W'(3), ADDR_W'(3)));
    for (int i = 0; i < int'(Depth); i++)
      step(1'($urandom_range(0, 1)), rand_addr(), rand_data(), 1'($urandom_range(0, 1)),
           rand_ra());
    step(1'b0, '0, '0, 1'b0, pair(ADDR_W'(3), ADDR_W'(7)));
    step(1'b0, '0, '0, 1'b0, pair('0, '1));

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), rand_addr(), rand_data(),
           1'($urandom_range(0, 399) == 0), rand_ra());
    while (busy_left > 0) idle(1);

    // Reset in the middle of a sweep restarts it from entry 0.
    step(1'b1, ADDR_W'(5), rand_data(), 1'b1, rand_ra());
    idle(500);
    do_reset(1);
    for (int i = 0; i < int'(Depth) + 4; i++) step(1'b0, '0, '0, 1'b0, rand_ra());
    step(1'b0, '0, '0, 1'b0, pair(ADDR_W'(5), '1));
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), rand_addr(), rand_data(), 1'b0, rand_ra());

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
